// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, captures {pc, word} into an in-order queue and hands entries downstream.
// Optional perf counters (stall_cycles, fetched) are enabled by defining FETCH_SEQ_PERF_EN.
module fetch_seq #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     en,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [ADDR_W-1:0]        fetch_arg,
    input  logic [DATA_W-1:0]        fetch_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [15:0]              stall_cycles,
    output logic [15:0]              fetched
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic [DATA_W-1:0]  data_mem_q [DEPTH];

    logic is_full;
    logic push;
    logic pop;

    assign is_full = (count_q == CNT_W'(DEPTH));
    assign pop     = out_valid & out_ready & ~redirect_valid;
    // A pop frees its slot in the same cycle, so a full queue can still fetch.
    assign push    = (state_q != IDLE) & en & ~redirect_valid & (~is_full | pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (state_q != IDLE) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                state_d = RUN;
            end
        end else begin
            if (push) begin
                pc_d   = pc_q + ADDR_W'(1);
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (state_q == IDLE) begin
                if (en) begin
                    state_d = RUN;
                end
            end else begin
                state_d = (count_d == CNT_W'(DEPTH)) ? FULL : RUN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads back as zero afterwards.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                pc_mem_q[gi]   <= '0;
                data_mem_q[gi] <= '0;
            end else if (push && (tail_q == PTR_W'(gi))) begin
                pc_mem_q[gi]   <= pc_q;
                data_mem_q[gi] <= fetch_data;
            end
        end
    end

    assign fetch_arg = pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = data_mem_q[head_q];
    assign out_pc    = pc_mem_q[head_q];
    assign count     = count_q;

`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] fetched_q, fetched_d;

    always_comb begin
        stall_d   = stall_q;
        fetched_d = fetched_q;
        if ((state_q != IDLE) && en && !redirect_valid && is_full && !pop && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        if (push && (fetched_q != 16'hFFFF)) begin
            fetched_d = fetched_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_q   <= '0;
            fetched_q <= '0;
        end else begin
            stall_q   <= stall_d;
            fetched_q <= fetched_d;
        end
    end

    assign stall_cycles = stall_q;
    assign fetched      = fetched_q;
`endif
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: stimulus queues expected PCs, a negedge monitor checks every handshake.
module tb_fetch_seq;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        en;
    logic        redirect_valid;
    logic [2:0]  redirect_pc;
    logic [2:0]  fetch_arg;
    logic [31:0] fetch_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_pc;
    logic [2:0]  count;
`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] fetched;
`endif

    logic [31:0] mem_tab [8];
    int total = 0;
    int bad   = 0;
    int exp_q [$];

    always #5 CLK = ~CLK;

    assign fetch_data = mem_tab[fetch_arg];

    fetch_seq dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_arg      (fetch_arg),
        .fetch_data     (fetch_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .fetched        (fetched)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_pcs(input int first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back((first + k) % 8);
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            total++;
            if (count > 3'd4) begin
                bad++;
                $display("FAIL count_bound actual=%0d required<=4", count);
            end
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop actual_pc=%0d required=none", out_pc);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    $display("pop pc=%0d instr=%h", out_pc, out_instr);
                    chk("pop_pc", {29'd0, out_pc}, e);
                    chk("pop_instr", out_instr, mem_tab[e]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_tab[0] = 32'hD82C07CD; mem_tab[1] = 32'h6BAA9455;
        mem_tab[2] = 32'h1F3E5D7C; mem_tab[3] = 32'hA5A5F00F;
        mem_tab[4] = 32'h0BADF00D; mem_tab[5] = 32'h81332876;
        mem_tab[6] = 32'h5EED1234; mem_tab[7] = 32'hCAFEBABE;
        RST_N = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step(2);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_fetch_arg", fetch_arg, 0);
        RST_N = 1'b1;

        // Streaming with out_ready held high
        expect_pcs(0, 10);
        en = 1'b1; out_ready = 1'b1;
        step(1);
        chk("t1_valid_early", out_valid, 0);
        step(1);
        chk("t1_valid_rise", out_valid, 1);
        chk("t1_first_pc", out_pc, 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t1_steady_count", count, 1);
        end
        en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 3'd0;
        step(1);
        redirect_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_fetch_arg", fetch_arg, 0);

        // Fill with out_ready low
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t2_fill_count", count, i + 1);
        end
        step(2);
        chk("t2_full_count", count, 4);
        chk("t2_fetch_arg", fetch_arg, 4);
        chk("t2_head_pc", out_pc, 0);
        chk("t2_head_instr", out_instr, 32'hD82C07CD);

        // Single-cycle pop while full
        expect_pcs(0, 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t3_count", count, 4);
        chk("t3_head_pc", out_pc, 1);
        chk("t3_fetch_arg", fetch_arg, 5);

        expect_pcs(1, 6);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("t2_drain_count", count, 4);
        end
        expect_pcs(7, 1);
        en = 1'b0;
        step(1);
        chk("t4_pre_count", count, 3);
        chk("t4_pre_head", out_pc, 0);

        // Redirect with three entries queued
        en = 1'b1; redirect_valid = 1'b1; redirect_pc = 3'd5;
        step(1);
        redirect_valid = 1'b0;
        chk("t4_count", count, 0);
        chk("t4_valid", out_valid, 0);
        chk("t4_fetch_arg", fetch_arg, 5);
        expect_pcs(5, 3);
        step(1);
        chk("t4_new_valid", out_valid, 1);
        chk("t4_new_pc", out_pc, 5);
        chk("t4_new_instr", out_instr, 32'h81332876);
        step(3);
        out_ready = 1'b0;
        chk("t4_tail_count", count, 1);
        chk("t4_tail_fetch_arg", fetch_arg, 1);

        // Reset mid-run with a full queue
        step(4);
        chk("t5_pre_count", count, 4);
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1; en = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_pc", out_pc, 0);
        chk("t5_instr", out_instr, 0);
        chk("t5_fetch_arg", fetch_arg, 0);
        step(2);
        chk("t5_idle_valid", out_valid, 0);
        chk("t5_idle_fetch_arg", fetch_arg, 0);
        expect_pcs(0, 3);
        en = 1'b1; out_ready = 1'b1;
        step(1);
        chk("t5_resume_early", out_valid, 0);
        step(1);
        chk("t5_resume_pc", out_pc, 0);
        chk("t5_resume_count", count, 1);
        step(3);
        out_ready = 1'b0; en = 1'b0;

        // Redirect while IDLE only loads the PC
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        en = 1'b1; redirect_valid = 1'b1; redirect_pc = 3'd6;
        step(1);
        redirect_valid = 1'b0;
        chk("idle_redir_fetch_arg", fetch_arg, 6);
        chk("idle_redir_count", count, 0);
        step(1);
        chk("idle_redir_nopush", count, 0);
        step(1);
        chk("idle_redir_count1", count, 1);
        chk("idle_redir_pc", out_pc, 6);
        chk("idle_redir_fetch_next", fetch_arg, 7);
        expect_pcs(6, 1);
        en = 1'b0; out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("idle_redir_drained", count, 0);

`ifdef FETCH_SEQ_PERF_EN
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        chk("perf_rst_stall", stall_cycles, 0);
        chk("perf_rst_fetched", fetched, 0);
        en = 1'b1;
        step(5);
        step(10);
        chk("perf_stall", stall_cycles, 10);
        chk("perf_fetched", fetched, 4);
        dut.stall_q = 16'hFFFF;
        step(2);
        chk("perf_stall_sat", stall_cycles, 16'hFFFF);
        en = 1'b0;
`endif

        step(2);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
